// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like responder: access-size codes,
// the queued request entry layout and the back-pressure LFSR constants.
package sram_like_pkg;

    // Access size codes carried on the size port (informational only)
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Word index keeps the full addr[31:2]; the top uses only the low ADDR_W bits
    localparam int IDX_W   = 30;
    // Wide enough for LATENCY-1 with LATENCY up to 15
    localparam int TIMER_W = 4;

    typedef struct packed {
        logic               wr;
        logic [3:0]         wstrb;
        logic [IDX_W-1:0]   idx;
        logic [31:0]        wdata;
        logic [TIMER_W-1:0] timer;
    } req_entry_t;

    // Fibonacci LFSR for x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sram_like_req_fifo.sv
// Circular queue of accepted-but-unanswered requests. Each entry carries a
// countdown timer that saturates at zero; the head entry is ready to retire
// once its timer has run out. At most one push and one pop per cycle.
module sram_like_req_fifo
    import sram_like_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  req_entry_t push_entry,
    input  logic       pop,
    output logic       head_ready,
    output req_entry_t head_entry,
    output logic [2:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    req_entry_t       entry_reg [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [2:0]       count_reg;

    function automatic logic [PTR_W-1:0] ptr_adv(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Per-slot storage: load on push, clear on pop, otherwise count the timer down
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_reg[gi] <= 1'b0;
                    entry_reg[gi] <= '0;
                end else if (push && wr_ptr_reg == PTR_W'(gi)) begin
                    valid_reg[gi] <= 1'b1;
                    entry_reg[gi] <= push_entry;
                end else begin
                    if (pop && rd_ptr_reg == PTR_W'(gi)) begin
                        valid_reg[gi] <= 1'b0;
                    end
                    if (valid_reg[gi] && entry_reg[gi].timer != '0) begin
                        entry_reg[gi].timer <= entry_reg[gi].timer - 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_adv(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_adv(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_entry = entry_reg[rd_ptr_reg];
    assign head_ready = valid_reg[rd_ptr_reg] && (entry_reg[rd_ptr_reg].timer == '0);
    assign count      = count_reg;

endmodule

// File: rtl/sram_like_resp.sv
// Responder end of the SRAM-like memory interface. Requests are accepted on
// req & addr_ok, queued in order, and retired one per cycle after LATENCY
// edges: reads load rdata from the word array, writes update the enabled
// byte lanes. The array is split into four byte-wide lanes so each lane maps
// onto a plain block RAM with a registered read.
// Optional build macro SRAM_LIKE_RESP_STALL_EN adds LFSR-driven random
// back-pressure on addr_ok.
module sram_like_resp
    import sram_like_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int DEPTH_WORDS = 1 << ADDR_W;

    logic              accept;
    logic              stall;
    logic [2:0]        count;
    logic              head_ready;
    req_entry_t        head_entry;
    req_entry_t        push_entry;
    logic [ADDR_W-1:0] head_idx;
    logic              data_ok_reg;
    logic              unused_bits;

`ifdef SRAM_LIKE_RESP_STALL_EN
    logic [7:0] lfsr_reg;

    // Free-running back-pressure pattern, restarted from the seed on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next(lfsr_reg);
        end
    end

    assign stall = lfsr_reg[0];
`else
    assign stall = 1'b0;
`endif

    // count is the registered occupancy, so a retire in this cycle cannot
    // open a slot for this cycle's addr_ok (no data_ok -> addr_ok path)
    assign accept  = req & ~reset & ~stall & (count < 3'(MAX_OUT));
    assign addr_ok = accept;

    // Package the incoming request with its countdown preloaded
    always_comb begin
        push_entry       = '0;
        push_entry.wr    = wr;
        push_entry.wstrb = wstrb;
        push_entry.idx   = addr[31:2];
        push_entry.wdata = wdata;
        push_entry.timer = TIMER_W'(LATENCY - 1);
    end

    sram_like_req_fifo #(
        .DEPTH (MAX_OUT)
    ) u_req_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_entry (push_entry),
        .pop        (head_ready),
        .head_ready (head_ready),
        .head_entry (head_entry),
        .count      (count)
    );

    assign head_idx = head_entry.idx[ADDR_W-1:0];

    // One-cycle response pulse for the entry retired at this edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_ok_reg <= 1'b0;
        end else begin
            data_ok_reg <= head_ready;
        end
    end

    assign data_ok = data_ok_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH_WORDS];
            logic [7:0] rdata_lane_reg;

            // Byte-lane write at retire time; array contents survive reset
            always_ff @(posedge clk) begin
                if (head_ready && head_entry.wr && head_entry.wstrb[gi]) begin
                    mem_lane[head_idx] <= head_entry.wdata[8*gi +: 8];
                end
            end

            // Registered read at retire time; holds its value across writes and idle cycles
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_lane_reg <= 8'h00;
                end else if (head_ready && !head_entry.wr) begin
                    rdata_lane_reg <= mem_lane[head_idx];
                end
            end

            assign rdata[8*gi +: 8] = rdata_lane_reg;
        end
    endgenerate

    // size is informational and the sub-word address bits are ignored
    assign unused_bits = ^{size, addr[1:0], head_entry.idx[IDX_W-1:ADDR_W], head_entry.timer};

endmodule
